oled_spi_receiver: RTL

- Synthesizable receiving end of the write-only OLED serial link driven by the team's OLED controller (clock, data, data/command select, panel reset, VDD/VBAT enables).
- Oversamples the link on the system clock and deserialises bytes MSB-first, each tagged command or data.
- Queues bytes in a small FIFO with a valid/ready output and tracks panel state (display on, rails, command count).
- Used as an on-chip loopback checker and simulation monitor for the controller.

---
 rtl/oled_spi_receiver_if.sv | 22 ++
 rtl/oled_spi_receiver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_receiver_if.sv
// Byte stream leaving the OLED link receiver: FIFO head plus valid/ready handshake.
// The receiver drives the head (master); the consumer drives ready (slave).
interface oled_spi_receiver_if;
   logic       out_byte_valid;
   logic       in_byte_ready;
   logic [7:0] out_byte_data;
   logic       out_byte_isData;

   modport master (
      output out_byte_valid,
      output out_byte_data,
      output out_byte_isData,
      input  in_byte_ready
   );

   modport slave (
      input  out_byte_valid,
      input  out_byte_data,
      input  out_byte_isData,
      output in_byte_ready
   );
endinterface

// File: rtl/oled_spi_receiver.sv
// Receiving end of the write-only OLED serial link. The link is oversampled on
// the system clock, bytes are deserialised MSB-first and tagged command/data,
// queued in a small FIFO and decoded to track panel state.
module oled_spi_receiver #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        in_oled_clk,
   input  logic                        in_oled_din,
   input  logic                        in_oled_isData,
   input  logic                        in_oled_reset,
   input  logic                        in_oled_vdd,
   input  logic                        in_oled_vbat,
   oled_spi_receiver_if.master         byte_if,
   output logic                        out_display_on,
   output logic                        out_power_ok,
   output logic [15:0]                 out_cmd_count,
   output logic                        out_overflow,
   output logic                        out_frame_error
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
   localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

   // Synchronised link inputs: {sclk, din, isData, panel_rst_n, vdd_n, vbat_n}
   logic [5:0] sync1, sync2;
   logic       sclk_s, din_s, isdata_s, panel_rst_n_s, vdd_n_s, vbat_n_s;
   logic       sclk_prev;
   logic       sclk_rise, sclk_edge;

   // Deserialiser state
   logic [7:0]    shift_reg;
   logic [2:0]    bit_cnt;
   logic          tag;
   logic [IW-1:0] idle_cnt;

   // FIFO state
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   // Per-cycle control
   logic       byte_done, tag_bad, timeout_err, push_req;
   logic       push, pop, full, overflow_set, cmd_accept;
   logic [7:0] byte_new;

   // Two-flop synchronisers on all six link inputs
   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {in_oled_clk, in_oled_din, in_oled_isData,
                   in_oled_reset, in_oled_vdd, in_oled_vbat};
         sync2 <= sync1;
      end
   end

   assign sclk_s        = sync2[5];
   assign din_s         = sync2[4];
   assign isdata_s      = sync2[3];
   assign panel_rst_n_s = sync2[2];
   assign vdd_n_s       = sync2[1];
   assign vbat_n_s      = sync2[0];

   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_edge = sclk_s ^ sclk_prev;

   // Previous synced SCLK for edge detection, and saturating idle counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sclk_prev <= 1'b0;
         idle_cnt  <= '0;
      end else begin
         sclk_prev <= sclk_s;
         if (sclk_edge)
            idle_cnt <= '0;
         else if (idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + IW'(1);
      end
   end

   // Byte completion, tag check, timeout and FIFO push/pop decisions
   // NOTE: every signal gets a default first so no path leaves a latch behind.
   always_comb begin
      byte_done    = 1'b0;
      tag_bad      = 1'b0;
      timeout_err  = 1'b0;
      push_req     = 1'b0;
      byte_new     = {shift_reg[6:0], din_s};
      full         = (count == FIFO_FULL);
      pop          = byte_if.out_byte_valid & byte_if.in_byte_ready;
      push         = 1'b0;
      overflow_set = 1'b0;
      cmd_accept   = 1'b0;
      if (panel_rst_n_s) begin
         if (sclk_rise) begin
            byte_done = (bit_cnt == 3'd7);
            tag_bad   = byte_done && (isdata_s != tag);
            push_req  = byte_done && !tag_bad;
         end else begin
            timeout_err = (bit_cnt != 3'd0) && (idle_cnt == IDLE_MAX);
         end
      end
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push         = push_req && (!full || pop);
      overflow_set = push_req && full && !pop;
      cmd_accept   = push && !tag;
   end

   // Shift register, bit counter and byte tag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         tag       <= 1'b0;
      end else if (!panel_rst_n_s) begin
         bit_cnt <= '0;
      end else if (sclk_rise) begin
         shift_reg <= byte_new;
         bit_cnt   <= bit_cnt + 3'd1;
         if (bit_cnt == 3'd0)
            tag <= isdata_s;
      end else if (timeout_err) begin
         bit_cnt <= '0;
      end
   end

   // FIFO storage
   // NOTE: the data array has no reset; validity comes only from the reset pointers/count.
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= {tag, byte_new};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign byte_if.out_byte_valid  = (count != '0);
   assign byte_if.out_byte_data   = byte_if.out_byte_valid ? mem[rd_ptr][7:0] : 8'h00;
   assign byte_if.out_byte_isData = byte_if.out_byte_valid ? mem[rd_ptr][8]   : 1'b0;

   // Panel state: display on/off, command count, rails and sticky error flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_display_on  <= 1'b0;
         out_power_ok    <= 1'b0;
         out_cmd_count   <= '0;
         out_overflow    <= 1'b0;
         out_frame_error <= 1'b0;
      end else begin
         out_power_ok <= !vdd_n_s && !vbat_n_s;
         if (!panel_rst_n_s || vdd_n_s)
            out_display_on <= 1'b0;
         else if (cmd_accept && byte_new == 8'hAF)
            out_display_on <= 1'b1;
         else if (cmd_accept && byte_new == 8'hAE)
            out_display_on <= 1'b0;
         if (cmd_accept)
            out_cmd_count <= out_cmd_count + 16'd1;
         if (overflow_set)
            out_overflow <= 1'b1;
         if (tag_bad || timeout_err)
            out_frame_error <= 1'b1;
      end
   end

endmodule
